receptor_rx: RTL and testbench
==============================

# receptor_rx

UART receiver, 8N1, LSB first. Recovers bytes from the serial line driven by the host PC and presents each byte on a parallel bus with a one-cycle valid strobe. It is the receive end of the serial link whose transmit end is `transmisor_Tx`, and it feeds the DMA/protocol logic of the microprocessor. The receiver samples each bit at its midpoint, validates the start bit, and flags framing errors.

## Interface
- `DIVISOR`, default 104: clock cycles per bit (12 MHz / 115200 baud). Must be ≥ 4. For simulation use 16.
- `clk`  in  1  system clock (12 MHz on ICEstick). One clock domain.
- `rstn`  in  1  global reset, asynchronous, active-low.
- `rx`  in  1  serial input from PC. Asynchronous to `clk`. Idle high.
- `dato`  out  8  last correctly received byte. Holds its value until the next good byte.
- `dato_valido`  out  1  one-cycle pulse when `dato` is updated.
- `error_trama`  out  1  one-cycle pulse when the stop bit samples as 0.
- `ocupado`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Synchronizer:
  - `rx` passes through 2 flops to form `rx_s`. Both flops reset to 1.
  - The FSM sees `rx_s` only, never raw `rx`.
- Counters:
  - Bit-timing counter has width ceil(log2(DIVISOR)).
  - 3-bit data-bit index.
  - 8-bit shift register: shifts right, new bit enters the MSB, so after 8 bits bit 0 is the first received.
- States:
  - IDLE: counter = 0. If `rx_s`=0, go to START.
  - START: count to DIVISOR/2−1 (integer division), then sample.
    - `rx_s`=0: start bit is valid. Clear counter and index, go to DATA.
    - `rx_s`=1: glitch. Return to IDLE with no output pulse.
  - DATA: count DIVISOR cycles, then sample `rx_s` into the shift register.
    - After 8 samples (index wraps 7→0), go to STOP.
  - STOP: count DIVISOR cycles, then sample.
    - `rx_s`=1: load `dato` from the shift register, pulse `dato_valido`, go to IDLE.
    - `rx_s`=0: pulse `error_trama`, leave `dato` unchanged, go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_s`=1, then go to IDLE. This handles a break or a stuck-low line without emitting a burst of false frames.
- Back-to-back frames:
  - A start bit that immediately follows a good stop bit is accepted.
  - Re-arming happens in IDLE the cycle after the stop sample.
- Mutual exclusion:
  - `dato_valido` and `error_trama` are never high in the same cycle.
  - Each pulse lasts exactly 1 cycle.
- Reset:
  - Asserting `rstn`=0 at any point, including mid-frame, forces the state below immediately.
  - A partial frame is discarded with no pulse.
  - After release, a line still low (mid-frame) sends the FSM into START. If the start check passes, it decodes garbage.
  - A line still low through a stop bit produces `error_trama` and then WAIT_IDLE. This is accepted behaviour.

## Timing
- Reset values:
  - FSM = IDLE
  - `dato`=8'h00, `dato_valido`=0, `error_trama`=0, `ocupado`=0
  - synchronizer flops = 1, counters = 0, shift register = 0
- Edge E definitions:
  - R0 = first rising edge at which `rx` is sampled low.
  - `rx_s` goes low after R1.
  - E = R2 is the edge where IDLE sees 0 and moves to START. `ocupado` is high from E onward.
- Sample edges, relative to E:
  - start bit at E + DIVISOR/2
  - data bit i (i=0..7) at E + DIVISOR/2 + (i+1)·DIVISOR
  - stop bit at E + DIVISOR/2 + 9·DIVISOR
- Outputs registered at the stop-sample edge:
  - `dato`, `dato_valido` and `error_trama` are registered at that edge.
  - The pulse is visible for the following cycle.
  - `ocupado` falls at the same edge on a good frame.
- Total latency, raw `rx` fall to `dato_valido`: 2 + DIVISOR/2 + 9·DIVISOR cycles. With DIVISOR=16 this is 154.
- Baud tolerance: mid-bit sampling tolerates about ±4.5% cumulative clock/baud mismatch over 10 bits.

## Test plan
- Reset: hold `rstn`=0 with `rx`=1.
  - Required: all outputs at reset values.
  - Required: FSM stays in IDLE after release.
- Single frame, DIVISOR=16: send 0xA5 at 16 clk/bit.
  - Required: `dato_valido` is high exactly 1 cycle, 154 cycles after the `rx` fall.
  - Required: `dato`=8'hA5, `error_trama` never high.
- Back-to-back frames: send 0x00, 0xFF, 0x3C with no idle gap.
  - Required: three `dato_valido` pulses, spaced 160 cycles apart, with `dato` = 00, FF, 3C.
- Glitch: pulse `rx` low for 3 cycles, then high.
  - Required: `ocupado` rises, then returns to 0 by E+8.
  - Required: no `dato_valido` and no `error_trama`.
- Framing error: send 0x55 with the stop bit driven 0, then hold `rx` low 50 cycles, then release.
  - Required: one `error_trama` pulse.
  - Required: `dato` keeps its previous value, FSM stays in WAIT_IDLE until `rx_s`=1.
  - Required: a following good 0x81 frame gives `dato`=8'h81.
- Reset mid-frame: assert `rstn` low during data bit 4 of 0xC3, release with `rx`=1, then send 0x12.
  - Required: no pulse for the aborted frame.
  - Required: `dato`=8'h12 with a single `dato_valido`.

Source files
------------

// File: rtl/receptor_rx.sv
// 8N1 UART receiver, LSB first: two-flop input synchronizer, mid-bit sampling,
// start-bit glitch rejection, framing-error detection and stuck-low line recovery.
module receptor_rx #(
   parameter int DIVISOR = 104
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       rx,
   output logic [7:0] dato,
   output logic       dato_valido,
   output logic       error_trama,
   output logic       ocupado
);

   localparam int CNT_W = $clog2(DIVISOR);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(DIVISOR / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(DIVISOR - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_WAIT_IDLE
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       sync_q, sync_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       dato_q, dato_d;
   logic             valido_q, valido_d;
   logic             error_q, error_d;
   logic             ocupado_q, ocupado_d;
   logic             rx_s;

   // rx is asynchronous to clk; only the second synchronizer stage reaches the FSM.
   assign rx_s   = sync_q[1];
   assign sync_d = {sync_q[0], rx};

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case infers a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      dato_d   = dato_q;
      valido_d = 1'b0;
      error_d  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = ST_START;
         end

         ST_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d = '0;
               if (!rx_s) begin
                  idx_d   = 3'd0;
                  state_d = ST_DATA;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_DATA: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[7:1]};
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = ST_STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_STOP: begin
            if (cnt_q == FULL_M1) begin
               cnt_d = '0;
               if (rx_s) begin
                  dato_d   = shift_q;
                  valido_d = 1'b1;
                  state_d  = ST_IDLE;
               end else begin
                  error_d = 1'b1;
                  state_d = ST_WAIT_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         // A break or stuck-low line must return high before a new start bit is armed.
         ST_WAIT_IDLE: begin
            cnt_d = '0;
            if (rx_s) state_d = ST_IDLE;
         end

         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase

      ocupado_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= ST_IDLE;
         sync_q    <= 2'b11;
         cnt_q     <= '0;
         idx_q     <= 3'd0;
         shift_q   <= 8'h00;
         dato_q    <= 8'h00;
         valido_q  <= 1'b0;
         error_q   <= 1'b0;
         ocupado_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q   <= state_d;
         sync_q    <= sync_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         dato_q    <= dato_d;
         valido_q  <= valido_d;
         error_q   <= error_d;
         ocupado_q <= ocupado_d;
      end
   end

   assign dato        = dato_q;
   assign dato_valido = valido_q;
   assign error_trama = error_q;
   assign ocupado     = ocupado_q;

endmodule

// File: tb/tb_receptor_rx.sv
// Self-checking bench for receptor_rx: vector table, directed corner sequences and
// randomized frames checked against a frame-level timing/data model.
module tb_receptor_rx;

   localparam int DIV   = 16;
   localparam int LAT   = 2 + DIV / 2 + 9 * DIV;
   localparam int FRAME = 10 * DIV;

   logic       clk = 1'b0;
   logic       rstn;
   logic       rx;
   logic [7:0] dato;
   logic       dato_valido;
   logic       error_trama;
   logic       ocupado;

   receptor_rx #(.DIVISOR(DIV)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .rx          (rx),
      .dato        (dato),
      .dato_valido (dato_valido),
      .error_trama (error_trama),
      .ocupado     (ocupado)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   // Output monitor, sampled on the falling edge.
   int valid_cnt = 0, err_cnt = 0;
   int last_valid_cyc = -1, last_err_cyc = -1;
   int valid_q[$];
   int run_v = 0, run_e = 0;
   bit wide_seen = 1'b0, both_seen = 1'b0;

   always @(negedge clk) begin
      if (dato_valido) begin
         valid_cnt++;
         last_valid_cyc = cyc;
         valid_q.push_back(cyc);
      end
      if (error_trama) begin
         err_cnt++;
         last_err_cyc = cyc;
      end
      run_v = dato_valido ? run_v + 1 : 0;
      run_e = error_trama ? run_e + 1 : 0;
      if (run_v > 1 || run_e > 1) wide_seen = 1'b1;
      if (dato_valido && error_trama) both_seen = 1'b1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drives one frame starting at the current falling edge; leaves rx at the stop value.
   task automatic send_frame(input logic [7:0] d, input logic stop, output int r0);
      rx = 1'b0;
      r0 = cyc + 1;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         repeat (DIV) @(negedge clk);
      end
      rx = stop;
      repeat (DIV) @(negedge clk);
   endtask

   logic [7:0] model_dato = 8'h00;

   // Frame-level model: a good stop yields one strobe LAT cycles after R0 carrying the
   // byte; a bad stop yields one error strobe at the same point and keeps the old byte.
   task automatic expect_frame(input string tag, input logic [7:0] d, input logic stop,
                               input int r0, input int v0, input int e0);
      if (stop) begin
         check({tag, " valid_count"}, valid_cnt - v0, 1);
         check({tag, " err_count"}, err_cnt - e0, 0);
         check({tag, " valid_latency"}, last_valid_cyc - r0, LAT);
         check({tag, " dato"}, dato, d);
         model_dato = d;
      end else begin
         check({tag, " err_count"}, err_cnt - e0, 1);
         check({tag, " valid_count"}, valid_cnt - v0, 0);
         check({tag, " err_latency"}, last_err_cyc - r0, LAT);
         check({tag, " dato_kept"}, dato, model_dato);
      end
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         exp_valid;
      int         exp_err;
      logic [7:0] exp_dato;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int r0, v0, e0, qi, gap;
      logic [7:0] d;
      logic stop;

      vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_valid: 1, exp_err: 0, exp_dato: 8'hA5};
      vecs[1] = '{data: 8'h5A, stop: 1'b0, exp_valid: 0, exp_err: 1, exp_dato: 8'hA5};
      vecs[2] = '{data: 8'h01, stop: 1'b1, exp_valid: 1, exp_err: 0, exp_dato: 8'h01};
      vecs[3] = '{data: 8'h80, stop: 1'b1, exp_valid: 1, exp_err: 0, exp_dato: 8'h80};

      // Reset with idle line.
      rstn = 1'b0;
      rx   = 1'b1;
      repeat (3) @(negedge clk);
      check("reset dato", dato, 8'h00);
      check("reset dato_valido", dato_valido, 0);
      check("reset error_trama", error_trama, 0);
      check("reset ocupado", ocupado, 0);
      rstn = 1'b1;
      repeat (20) @(negedge clk);
      check("post-reset ocupado", ocupado, 0);
      check("post-reset pulses", valid_cnt + err_cnt, 0);

      // Vector table.
      for (int i = 0; i < 4; i++) begin
         v0 = valid_cnt;
         e0 = err_cnt;
         send_frame(vecs[i].data, vecs[i].stop, r0);
         check($sformatf("vec%0d valid_count", i), valid_cnt - v0, vecs[i].exp_valid);
         check($sformatf("vec%0d err_count", i), err_cnt - e0, vecs[i].exp_err);
         check($sformatf("vec%0d dato", i), dato, vecs[i].exp_dato);
         if (vecs[i].exp_valid == 1)
            check($sformatf("vec%0d valid_latency", i), last_valid_cyc - r0, LAT);
         else
            check($sformatf("vec%0d err_latency", i), last_err_cyc - r0, LAT);
         rx = 1'b1;
         repeat (2 * DIV) @(negedge clk);
         check($sformatf("vec%0d idle ocupado", i), ocupado, 0);
      end
      model_dato = vecs[3].exp_dato;

      // Back-to-back frames, no idle gap.
      qi = valid_q.size();
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(8'h00, 1'b1, r0);
      expect_frame("b2b0", 8'h00, 1'b1, r0, v0, e0);
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(8'hFF, 1'b1, r0);
      expect_frame("b2b1", 8'hFF, 1'b1, r0, v0, e0);
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(8'h3C, 1'b1, r0);
      expect_frame("b2b2", 8'h3C, 1'b1, r0, v0, e0);
      check("b2b pulse count", valid_q.size() - qi, 3);
      if (valid_q.size() >= qi + 3) begin
         check("b2b spacing 1", valid_q[qi+1] - valid_q[qi], FRAME);
         check("b2b spacing 2", valid_q[qi+2] - valid_q[qi+1], FRAME);
      end
      rx = 1'b1;
      repeat (2 * DIV) @(negedge clk);

      // Glitch: three low cycles on rx.
      v0 = valid_cnt; e0 = err_cnt;
      rx = 1'b0;
      r0 = cyc + 1;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      while (cyc < r0 + 2) @(negedge clk);
      check("glitch ocupado at E", ocupado, 1);
      while (cyc < r0 + 2 + DIV / 2) @(negedge clk);
      check("glitch ocupado at E+half", ocupado, 0);
      repeat (FRAME) @(negedge clk);
      check("glitch pulses", (valid_cnt - v0) + (err_cnt - e0), 0);

      // Framing error, stuck-low line, then recovery.
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(8'h55, 1'b0, r0);
      expect_frame("ferr", 8'h55, 1'b0, r0, v0, e0);
      repeat (50) @(negedge clk);
      check("ferr wait ocupado", ocupado, 1);
      check("ferr single pulse", err_cnt - e0, 1);
      check("ferr dato held", dato, model_dato);
      rx = 1'b1;
      repeat (5) @(negedge clk);
      check("ferr released ocupado", ocupado, 0);
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(8'h81, 1'b1, r0);
      expect_frame("ferr recover", 8'h81, 1'b1, r0, v0, e0);
      rx = 1'b1;
      repeat (2 * DIV) @(negedge clk);

      // Reset during data bit 4 of 0xC3.
      v0 = valid_cnt; e0 = err_cnt;
      d = 8'hC3;
      rx = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = d[i];
         repeat (DIV) @(negedge clk);
      end
      rx = d[4];
      repeat (DIV / 2) @(negedge clk);
      rstn = 1'b0;
      rx   = 1'b1;
      repeat (2) @(negedge clk);
      check("midreset ocupado", ocupado, 0);
      check("midreset dato", dato, 8'h00);
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      model_dato = 8'h00;
      repeat (6 * DIV) @(negedge clk);
      check("midreset no pulse", (valid_cnt - v0) + (err_cnt - e0), 0);
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(8'h12, 1'b1, r0);
      expect_frame("after reset", 8'h12, 1'b1, r0, v0, e0);
      rx = 1'b1;
      repeat (2 * DIV) @(negedge clk);

      // Randomized frames with random gaps and occasional bad stop bits.
      for (int n = 0; n < 24; n++) begin
         d    = 8'($urandom);
         stop = ($urandom_range(0, 3) != 0);
         v0 = valid_cnt; e0 = err_cnt;
         send_frame(d, stop, r0);
         expect_frame($sformatf("rand%0d", n), d, stop, r0, v0, e0);
         rx  = 1'b1;
         gap = stop ? int'($urandom_range(0, 3)) : int'($urandom_range(2, 5));
         repeat (gap) @(negedge clk);
      end
      repeat (2 * DIV) @(negedge clk);

      check("pulse width one cycle", wide_seen, 0);
      check("valid/error exclusive", both_seen, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
